led_run_arbiter: RTL
====================

Name: led_run_arbiter

Overview:
Shares the single LED count datapath (CW-bit up-counter, 0..limit) between two run requesters, typically the two debounced "go" buttons. It grants one requester at a time, runs the count at the dividedClock rate up to that requester's limit, and pulses a per-requester done.
It also pulses abort if the owner drops its request mid-run. It sits between the button front-end and the LED output assignment.

Parameters:
CW, 4, width of count and of each limit input
DEF_LAST, 1, round-robin pointer reset value (1 means requester 0 wins the first tie)

Ports:
dividedClock  in  1  block clock
rst  in  1  reset; asynchronous, active-high
req  in  2  run request per requester, level-sensitive, held for the duration of the run
limit0  in  CW  terminal count for requester 0; sampled only at grant
limit1  in  CW  terminal count for requester 1; sampled only at grant
grant  out  2  one-hot owner of the counter; 2'b00 when idle
busy  out  1  high while in COUNT
count  out  CW  current count value to the LEDs
done  out  2  one-cycle pulse to the owner on run completion
abort  out  2  one-cycle pulse to the owner on a withdrawn run
last  out  1  index of the most recent owner (round-robin pointer)

Behaviour:
- Reset is asynchronous, active-high, on clock dividedClock.
  - While rst=1: state=IDLE, grant=0, busy=0, count=0, done=0, abort=0, last=DEF_LAST, lim_q=0.
  - Reset mid-run drops the grant immediately, with no done or abort pulse.
- All outputs are registered. done and abort are high for exactly one cycle.
- State machine (2 states, encoded in a 1-bit register):
  - IDLE
    - count=0, grant=0, busy=0.
    - At an edge with req!=0: pick the winner.
      - Only one request: that requester wins.
      - Both requesting: winner = ~last (round robin).
    - On that edge: grant<=onehot(winner), lim_q<=limit of the winner, count<=0, busy<=1, state<=COUNT.
    - Latency: req sampled high at edge k gives grant visible after edge k.
  - COUNT
    - Each edge, evaluated in priority order:
      1. req[owner]==0 (withdrawn): abort[owner]<=1, grant<=0, busy<=0, count<=0, last<=owner, state<=IDLE.
      2. Else count==lim_q: done[owner]<=1, grant<=0, busy<=0, count<=0, last<=owner, state<=IDLE.
      3. Else count<=count+1.
    - The non-owner req is ignored during COUNT; it is neither queued nor lost, simply re-sampled in IDLE.
- Run length:
  - A run with limit L shows count 0..L and spans L+1 COUNT cycles.
  - The done edge is the (L+1)th edge after the grant edge.
  - L=0 gives a 1-cycle grant and a done pulse on the next edge.
  - L=2^CW-1 runs to all-ones. count never wraps, because the terminal compare precedes the increment.
- After done or abort, at least one IDLE cycle elapses before the next grant. Grant therefore deasserts for ≥1 cycle between back-to-back runs.
- A requester holding req high after done is re-granted only if the other requester is not requesting.
- lim_q is frozen for the whole run; changing limitX mid-run has no effect.
- The done/abort bit always matches the grant bit of the run that ended.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, with requester 0 always winning a tie. last still updates for observation only. Requester 1 can starve.
- Undefined: round robin as above.
- Ports and all other timing are identical in both builds.

Test Plan:
- rst pulse then req=2'b01, limit0=3 → grant=01 after 1st edge; count 0,1,2,3 on following cycles; done=01 for one cycle on 5th edge; grant=00, last=0.
- req=2'b11 held, limit0=1, limit1=2, from reset (last=1) → runs alternate: owner 0 (2 cycles) then IDLE 1 cycle, then owner 1 (3 cycles), then owner 0 again. done pulses alternate 01,10. With ARB_FIXED_PRIO_EN, owner is always 0.
- req=2'b10, limit1=15, drop req[1] while count=6 → abort=10 one cycle; no done; count=0, grant=00 next cycle.
- limit0=0, req=2'b01 → grant=01 for exactly one cycle with count=0; done=01 on next edge.
- rst asserted asynchronously mid-run (count=9) → grant, busy, count, done, abort = 0 immediately; last=DEF_LAST; no pulse after release.
- limit0 changed from 5 to 2 at count=3 → run still ends at count=5 with done.

Source files
------------

// File: rtl/led_run_arbiter.sv
// Two-requester arbiter sharing one LED up-counter: grants a single owner, counts 0..limit, pulses done/abort.
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of round robin.
module led_run_arbiter #(
  parameter int CW       = 4,
  parameter int DEF_LAST = 1
) (
  input  logic          dividedClock,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [CW-1:0] limit0,
  input  logic [CW-1:0] limit1,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic [1:0]    done,
  output logic [1:0]    abort,
  output logic          last
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic LAST_INIT = (DEF_LAST != 0);

  state_t        state;
  logic [CW-1:0] lim_q;
  logic          owner;
  logic          winner;

  // grant is one-hot while counting, so its upper bit names the owner
  assign owner = grant[1];

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner = ~req[0];
`else
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
`endif
  end

  always_ff @(posedge dividedClock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      busy  <= 1'b0;
      count <= '0;
      done  <= 2'b00;
      abort <= 2'b00;
      last  <= LAST_INIT;
      lim_q <= '0;
    end else begin
      done  <= 2'b00;
      abort <= 2'b00;
      if (state == IDLE) begin
        count <= '0;
        if (req != 2'b00) begin
          grant <= winner ? 2'b10 : 2'b01;
          lim_q <= winner ? limit1 : limit0;
          busy  <= 1'b1;
          state <= COUNT;
        end
      end else begin
        // withdrawal outranks completion; terminal compare precedes the increment so count never wraps
        if (!req[owner]) begin
          abort <= grant;
          grant <= 2'b00;
          busy  <= 1'b0;
          count <= '0;
          last  <= owner;
          state <= IDLE;
        end else if (count == lim_q) begin
          done  <= grant;
          grant <= 2'b00;
          busy  <= 1'b0;
          count <= '0;
          last  <= owner;
          state <= IDLE;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule
